// File: rtl/xm_bus_arbiter.sv
// xm_bus_arbiter: two-master, one-slave Wishbone classic arbiter.
// Round-robin grant held for a whole cyc burst. A stb watchdog aborts
// transfers to a slave that never acks. Owners always change via IDLE,
// so there is at least one s_cyc_o-low cycle between different owners.
module xm_bus_arbiter #(
  parameter int WORD    = 16,
  parameter int ADRW    = 15,
  parameter int TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            arst_i,
  // master 0 (CPU memory controller)
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [1:0]      m0_sel_i,
  input  logic [ADRW-1:0] m0_adr_i,
  input  logic [WORD-1:0] m0_dat_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic [WORD-1:0] m0_dat_o,
  // master 1 (DMA / debug)
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [1:0]      m1_sel_i,
  input  logic [ADRW-1:0] m1_adr_i,
  input  logic [WORD-1:0] m1_dat_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [WORD-1:0] m1_dat_o,
  // slave port
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [1:0]      s_sel_o,
  output logic [ADRW-1:0] s_adr_o,
  output logic [WORD-1:0] s_dat_o,
  input  logic            s_ack_i,
  input  logic [WORD-1:0] s_dat_i,
  output logic [1:0]      gnt_o
);

  // A zero TIMEOUT still needs a legal 1-bit counter; it is simply never compared.
  localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

  typedef struct packed {
    logic            cyc;
    logic            stb;
    logic            we;
    logic [1:0]      sel;
    logic [ADRW-1:0] adr;
    logic [WORD-1:0] dat;
  } req_t;

  req_t [1:0]  mReq;
  req_t        cur;
  state_t      state;
  logic        last;
  logic        busy;
  logic        own;
  logic        stall;
  logic        wdHit;
  logic [CW-1:0] wdCnt;
  logic [1:0]  errQ;
  logic [1:0]  gntQ;

  assign mReq[0] = {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i};
  assign mReq[1] = {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i};

  assign busy  = (state == GNT0) || (state == GNT1);
  assign own   = (state == GNT1);
  assign cur   = mReq[own];
  assign stall = busy && cur.stb && !s_ack_i;
  // Trip on the stalled cycle that would take the count to TIMEOUT; an ack
  // in that same cycle clears stall, so the ack wins.
  assign wdHit = (TIMEOUT != 0) && stall && (wdCnt == CW'(LIM));

  // Slave side is a plain mux of the owner; everything is low outside GNTn.
  assign s_cyc_o = busy && cur.cyc;
  assign s_stb_o = busy && cur.stb;
  assign s_we_o  = busy && cur.we;
  assign s_sel_o = busy ? cur.sel : '0;
  assign s_adr_o = busy ? cur.adr : '0;
  assign s_dat_o = busy ? cur.dat : '0;

  assign m0_ack_o = (state == GNT0) && s_ack_i && s_stb_o;
  assign m1_ack_o = (state == GNT1) && s_ack_i && s_stb_o;
  assign m0_err_o = errQ[0];
  assign m1_err_o = errQ[1];
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt_o    = gntQ;

  // Arbitration FSM with watchdog; err and gnt are registered with the state.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state <= IDLE;
      last  <= 1'b1;
      wdCnt <= '0;
      errQ  <= '0;
      gntQ  <= '0;
    end else begin
      errQ <= '0;
      case (state)
        IDLE: begin
          wdCnt <= '0;
          if (m0_cyc_i && (!m1_cyc_i || last)) begin
            state <= GNT0;
            last  <= 1'b0;
            gntQ  <= 2'b01;
          end else if (m1_cyc_i) begin
            state <= GNT1;
            last  <= 1'b1;
            gntQ  <= 2'b10;
          end
        end
        GNT0, GNT1: begin
          if (!cur.cyc) begin
            state <= IDLE;
            gntQ  <= '0;
            wdCnt <= '0;
          end else if (wdHit) begin
            state     <= ABORT;
            gntQ      <= '0;
            wdCnt     <= '0;
            errQ[own] <= 1'b1;
          end else if (stall) begin
            wdCnt <= wdCnt + 1'b1;
          end else begin
            wdCnt <= '0;
          end
        end
        ABORT: begin
          // last still names the aborted master; wait for it to let go.
          if (!mReq[last].cyc) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xm_bus_arbiter.sv
// Directed bench for xm_bus_arbiter (TIMEOUT = 8).
module tb_xm_bus_arbiter;

  localparam int WORD = 16;
  localparam int ADRW = 15;

  logic            clk_i, arst_i;
  logic            m0_cyc_i, m0_stb_i, m0_we_i;
  logic [1:0]      m0_sel_i;
  logic [ADRW-1:0] m0_adr_i;
  logic [WORD-1:0] m0_dat_i;
  logic            m0_ack_o, m0_err_o;
  logic [WORD-1:0] m0_dat_o;
  logic            m1_cyc_i, m1_stb_i, m1_we_i;
  logic [1:0]      m1_sel_i;
  logic [ADRW-1:0] m1_adr_i;
  logic [WORD-1:0] m1_dat_i;
  logic            m1_ack_o, m1_err_o;
  logic [WORD-1:0] m1_dat_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [1:0]      s_sel_o;
  logic [ADRW-1:0] s_adr_o;
  logic [WORD-1:0] s_dat_o;
  logic            s_ack_i;
  logic [WORD-1:0] s_dat_i;
  logic [1:0]      gnt_o;

  int nVec  = 0;
  int nMiss = 0;
  logic [WORD-1:0] burst [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};

  xm_bus_arbiter #(.WORD(WORD), .ADRW(ADRW), .TIMEOUT(8)) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .gnt_o(gnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMiss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    arst_i = 1'b0;
    {m0_cyc_i, m0_stb_i, m0_we_i} = '0; m0_sel_i = 2'b11; m0_adr_i = '0; m0_dat_i = '0;
    {m1_cyc_i, m1_stb_i, m1_we_i} = '0; m1_sel_i = 2'b11; m1_adr_i = '0; m1_dat_i = '0;
    s_ack_i = 1'b0; s_dat_i = 16'h1234;

    // reset state
    repeat (2) @(posedge clk_i);
    #3;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_scyc", s_cyc_o, 0);
    chk("rst_sstb", s_stb_o, 0);
    chk("rst_sadr", s_adr_o, 0);
    chk("rst_m0ack", m0_ack_o, 0);
    chk("rst_m1err", m1_err_o, 0);
    chk("rst_m0dat", m0_dat_o, 16'h1234);
    chk("rst_m1dat", m1_dat_o, 16'h1234);
    arst_i = 1'b1;
    step();

    // single master read
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 15'h0100;
    #2 chk("t1_lat_scyc", s_cyc_o, 0);
    step(); #2;
    chk("t1_gnt", gnt_o, 2'b01);
    chk("t1_scyc", s_cyc_o, 1);
    chk("t1_sadr", s_adr_o, 15'h0100);
    chk("t1_noack", m0_ack_o, 0);
    step();
    s_ack_i = 1; s_dat_i = 16'hBEEF;
    #2;
    chk("t1_ack", m0_ack_o, 1);
    chk("t1_dat", m0_dat_o, 16'hBEEF);
    chk("t1_m1ack", m1_ack_o, 0);
    step();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    step();

    // reset pulse, then tie and round-robin
    #2 arst_i = 1'b0;
    #2 arst_i = 1'b1;
    step();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 15'h0AAA;
    m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 15'h0555;
    step(); #2;
    chk("t2_tie_gnt", gnt_o, 2'b01);
    chk("t2_tie_adr", s_adr_o, 15'h0AAA);
    s_ack_i = 1;
    #1;
    chk("t2_m0ack", m0_ack_o, 1);
    chk("t2_m1stall", m1_ack_o, 0);
    step();
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    #2 chk("t2_drop_scyc", s_cyc_o, 0);
    step(); #2;
    chk("t2_gap_gnt", gnt_o, 0);
    chk("t2_gap_scyc", s_cyc_o, 0);
    step(); #2;
    chk("t2_rr_gnt", gnt_o, 2'b10);
    chk("t2_rr_adr", s_adr_o, 15'h0555);
    chk("t2_rr_scyc", s_cyc_o, 1);
    m1_cyc_i = 0; m1_stb_i = 0;
    step();
    m0_cyc_i = 1; m1_cyc_i = 1;
    step(); #2;
    chk("t2_tie2_gnt", gnt_o, 2'b01);
    m0_cyc_i = 0; m1_cyc_i = 0;
    step(); step();

    // burst hold: m1 wins the tie (last = 0) and keeps the bus for 4 writes
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 15'h0020; m1_dat_i = burst[0];
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 15'h0300;
    step(); #2;
    chk("t3_gnt", gnt_o, 2'b10);
    for (int i = 0; i < 4; i++) begin
      m1_dat_i = burst[i]; m1_adr_i = 15'h0020 + 15'(i); s_ack_i = 1;
      #2;
      chk("t3_sdat", s_dat_o, burst[i]);
      chk("t3_sadr", s_adr_o, 15'h0020 + 15'(i));
      chk("t3_we", s_we_o, 1);
      chk("t3_m1ack", m1_ack_o, 1);
      chk("t3_m0ack", m0_ack_o, 0);
      step();
    end
    s_ack_i = 0;
    #2 chk("t3_hold_gnt", gnt_o, 2'b10);
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
    step(); #2;
    chk("t3_gap_gnt", gnt_o, 0);
    chk("t3_gap_scyc", s_cyc_o, 0);
    step(); #2;
    chk("t3_m0_gnt", gnt_o, 2'b01);
    chk("t3_m0_adr", s_adr_o, 15'h0300);
    m0_cyc_i = 0; m0_stb_i = 0;
    step();

    // timeout: 8 stalled cycles, then err pulse and ABORT
    m0_cyc_i = 1; m0_stb_i = 1;
    step();
    for (int i = 1; i <= 8; i++) begin
      #2 chk("t4_noerr", m0_err_o, 0);
      step();
    end
    #2;
    chk("t4_err", m0_err_o, 1);
    chk("t4_scyc", s_cyc_o, 0);
    chk("t4_sstb", s_stb_o, 0);
    chk("t4_gnt", gnt_o, 0);
    chk("t4_m1err", m1_err_o, 0);
    step();
    s_ack_i = 1;
    #2;
    chk("t4_err_once", m0_err_o, 0);
    chk("t4_late_ack", m0_ack_o, 0);
    chk("t4_abort_scyc", s_cyc_o, 0);
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    step(); #2;
    chk("t4_idle_gnt", gnt_o, 0);
    step();

    // ack on the 8th stalled cycle wins over the watchdog
    m0_cyc_i = 1; m0_stb_i = 1;
    step();
    for (int i = 1; i <= 7; i++) begin
      #2 chk("t5_noerr", m0_err_o, 0);
      step();
    end
    s_ack_i = 1;
    #2 chk("t5_ack", m0_ack_o, 1);
    step();
    s_ack_i = 0;
    #2;
    chk("t5_err", m0_err_o, 0);
    chk("t5_gnt", gnt_o, 2'b01);
    chk("t5_scyc", s_cyc_o, 1);
    m0_cyc_i = 0; m0_stb_i = 0;
    step();

    // reset in the middle of a GNT1 transfer
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 15'h0042; m1_dat_i = 16'h5A5A;
    step(); #2;
    chk("t6_gnt", gnt_o, 2'b10);
    chk("t6_scyc", s_cyc_o, 1);
    s_ack_i = 1; arst_i = 0;
    #1;
    chk("t6_rst_scyc", s_cyc_o, 0);
    chk("t6_rst_sstb", s_stb_o, 0);
    chk("t6_rst_swe", s_we_o, 0);
    chk("t6_rst_sadr", s_adr_o, 0);
    chk("t6_rst_sdat", s_dat_o, 0);
    chk("t6_rst_gnt", gnt_o, 0);
    chk("t6_rst_ack", m1_ack_o, 0);
    chk("t6_rst_err", m1_err_o, 0);
    s_ack_i = 0;
    #2 arst_i = 1;
    step(); #2;
    chk("t6_regnt", gnt_o, 2'b10);
    chk("t6_rescyc", s_cyc_o, 1);
    chk("t6_readr", s_adr_o, 15'h0042);
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule

// File: doc/xm_bus_arbiter.md
# xm_bus_arbiter

Two-master, one-slave Wishbone classic arbiter for the XMakina system bus. It lets the CPU memory controller (master 0) and a secondary master such as a DMA or debug port (master 1) share a single memory/peripheral slave. The grant is round-robin and held for the whole `cyc` burst. A watchdog terminates transfers to a slave that never acknowledges. It sits between the CPU bus outputs and the system slave port.

## Interface
Parameters:
- `WORD`, 16, data width in bits.
- `ADRW`, 15, address width; equals the CPU `adr` width, WORD-(WORD/8)+1.
- `TIMEOUT`, 255, cycles of unacknowledged `stb` before an error is raised; 0 disables the watchdog.

Ports (N ∈ {0,1}, one set per master):
- `clk_i`  in  1  single system clock, rising edge.
- `arst_i`  in  1  asynchronous, active-low reset.
- `mN_cyc_i`  in  1  bus cycle request/hold from master N.
- `mN_stb_i`  in  1  transfer strobe from master N.
- `mN_we_i`  in  1  write enable from master N.
- `mN_sel_i`  in  2  byte selects from master N.
- `mN_adr_i`  in  ADRW  address from master N.
- `mN_dat_i`  in  WORD  write data from master N.
- `mN_ack_o`  out  1  acknowledge to master N.
- `mN_err_o`  out  1  one-cycle timeout error to master N.
- `mN_dat_o`  out  WORD  read data to master N; `s_dat_i` broadcast to both masters.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  slave cycle, strobe and write enable.
- `s_sel_o`  out  2  slave byte selects.
- `s_adr_o`  out  ADRW  slave address.
- `s_dat_o`  out  WORD  slave write data.
- `s_ack_i`  in  1  slave acknowledge.
- `s_dat_i`  in  WORD  slave read data.
- `gnt_o`  out  2  one-hot current owner; 00 when the bus is unowned.

## Operation
- FSM states: `IDLE`, `GNT0`, `GNT1`, `ABORT`. A `last` register holds the most recently granted master.
- **IDLE**
  - One requester (`cyc` high): move to its GNT state.
  - Both requesting: grant the master ≠ `last`.
  - Otherwise stay in `IDLE`.
- **GNTn**
  - Slave outputs are combinationally muxed from master n; `s_cyc_o` = `mn_cyc_i`.
  - `mn_ack_o` = `s_ack_i & s_stb_o`. The non-granted master gets ack = 0 and err = 0 and stalls.
  - Entering GNTn sets `last` = n.
  - `mn_cyc_i` low: return to `IDLE`.
- **Watchdog**
  - In GNTn, a counter increments each cycle with `s_stb_o & ~s_ack_i`.
  - The counter clears on ack, when `stb` is low, and on state exit.
  - When the counter reaches TIMEOUT: pulse `mn_err_o` for exactly one cycle, enter `ABORT`, and force `s_cyc_o`/`s_stb_o` low.
  - Counter width is $clog2(TIMEOUT+1).
- **ABORT**: all slave strobes are low. Wait until `mn_cyc_i` is low, then go to `IDLE`. A late `s_ack_i` is ignored.
- Ownership changes only through `IDLE`, so the bus always has at least one `s_cyc_o`-low cycle between owners.
- `gnt_o`: 01 in `GNT0`, 10 in `GNT1`, 00 in `IDLE` and `ABORT`.

## Timing
- **Reset** (asynchronous, `arst_i` = 0):
  - State `IDLE`, `last` = 1 (master 0 wins the first tie), counter = 0.
  - All `s_*` outputs, `mN_ack_o`, `mN_err_o` and `gnt_o` are 0.
  - `mN_dat_o` follows `s_dat_i`.
  - Reset asserted mid-transfer drops `s_cyc_o` immediately. No ack or err is issued.
- **Arbitration latency**: `cyc` sampled high in `IDLE` at edge k gives the grant from edge k; `s_cyc_o` and `s_stb_o` are asserted in the cycle after the request is first seen.
- **Data path**: ack and data pass through combinationally with zero added latency.
- **Simultaneous events**:
  - In `GNTn`, `mn_cyc_i` falling while the other master requests: next state is `IDLE`, and the other master is granted one cycle later.
  - An ack arriving in the same cycle the counter would hit TIMEOUT wins: the transfer completes normally and no err is raised.
- **Rate**: back-to-back `stb` within one held `cyc` runs at one transfer per acked cycle without rearbitration.

## Test plan
- **Single master read**: after reset, m0 `cyc`/`stb`/`adr`=0x0100. Slave acks in cycle 2 with 0xBEEF → m0 gets ack and data 0xBEEF, `gnt_o`=01, m1 ack stays 0.
- **Tie then round-robin**: m0 and m1 request together at reset → m0 is granted first. m0 drops `cyc` → one `IDLE` cycle with `s_cyc_o`=0, then `gnt_o`=10. Repeat the tie → m0 again, since `last`=1.
- **Burst hold**: m1 performs 4 back-to-back writes (0x11..0x44) under a held `cyc` while m0 requests → all 4 reach the slave. m0 is granted only after m1 drops `cyc`.
- **Timeout**: TIMEOUT=8, m0 strobes and the slave never acks → `m0_err_o` is high for exactly 1 cycle after 8 stalled cycles, `s_cyc_o` goes low, and state holds in `ABORT` until m0 drops `cyc`.
- **Ack at the limit**: the slave acks on the 8th stalled cycle → normal ack and no err.
- **Reset mid-transfer**: assert `arst_i` low while in `GNT1` with `stb` high → all outputs are 0 in the same cycle. After release, an m1-only request is granted normally.
